segment_scan_driver: RTL

//  Time-multiplexed N-digit 7-segment display driver for the clock design.

---
 rtl/segment_scan_driver.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/segment_scan_driver.sv
// Purpose : time-multiplexed N-digit 7-segment driver with tear-free frame updates,
//           leading-zero blanking and anti-ghost guard time (hex A-F via SEG_HEX_EN).
// Latency : outputs are registered, one cycle behind the internal (prescaler, slot) state.
// Backpressure: none; a load is always accepted and the newest pending load wins.
module segment_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int SCAN_DIV    = 1000,
    parameter int GUARD       = 2,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_in,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an_out,
    output logic                  frame_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] I_LAST  = IW'(DIGITS - 1);
    localparam logic [PW-1:0] GUARD_P = PW'(GUARD);

    // Segment patterns {g,f,e,d,c,b,a}; 10-15 are letters only in hex builds.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3f;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5b;
            4'd3:    s = 7'h4f;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6d;
            4'd6:    s = 7'h7d;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7f;
            4'd9:    s = 7'h6f;
`ifdef SEG_HEX_EN
            4'd10:   s = 7'h77;
            4'd11:   s = 7'h7c;
            4'd12:   s = 7'h39;
            4'd13:   s = 7'h5e;
            4'd14:   s = 7'h79;
            4'd15:   s = 7'h71;
`endif
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Scan position and digit storage.
    logic [PW-1:0]         p_q, p_d;
    logic [IW-1:0]         i_q, i_d;
    logic [4*DIGITS-1:0]   act_dig_q, act_dig_d;
    logic [DIGITS-1:0]     act_dp_q, act_dp_d;
    logic [4*DIGITS-1:0]   pend_dig_q, pend_dig_d;
    logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic                  pend_vld_q, pend_vld_d;

    // Registered outputs.
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  ft_q, ft_d;

    logic                  p_last, i_last, boundary;
    logic [3:0]            dig_arr [DIGITS];
    logic [DIGITS-1:0]     sup;
    logic                  run_zero;

    // Prescaler/slot advance; the last cycle of the last slot is the frame boundary.
    always_comb begin
        p_last   = (p_q == P_LAST);
        i_last   = (i_q == I_LAST);
        boundary = p_last && i_last;
        p_d      = p_last ? '0 : p_q + 1'b1;
        i_d      = i_q;
        if (p_last) begin
            i_d = i_last ? '0 : i_q + 1'b1;
        end
    end

    // Display contents only swap at the frame boundary; a load in that very cycle
    // goes straight to the active copy and supersedes anything pending.
    always_comb begin
        act_dig_d  = act_dig_q;
        act_dp_d   = act_dp_q;
        pend_dig_d = pend_dig_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;
        if (boundary) begin
            if (load) begin
                act_dig_d = digits_in;
                act_dp_d  = dp_in;
            end else if (pend_vld_q) begin
                act_dig_d = pend_dig_q;
                act_dp_d  = pend_dp_q;
            end
            pend_vld_d = 1'b0;
        end else if (load) begin
            pend_dig_d = digits_in;
            pend_dp_d  = dp_in;
            pend_vld_d = 1'b1;
        end
    end

    // Leading-zero mask: walk down from the top digit while everything seen is zero.
    always_comb begin
        run_zero = 1'b1;
        sup      = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            dig_arr[k] = act_dig_q[4*k +: 4];
            run_zero   = run_zero & (act_dig_q[4*k +: 4] == 4'd0);
            sup[k]     = (LZ_SUPPRESS != 0) && (k != 0) && run_zero;
        end
    end

    // Output next-state from the current slot: anodes dark during guard or blank.
    always_comb begin
        seg_d = sup[i_q] ? 7'h00 : seg_decode(dig_arr[i_q]);
        dp_d  = act_dp_q[i_q];
        an_d  = '0;
        if ((p_q >= GUARD_P) && !blank_in) begin
            an_d = DIGITS'(1) << i_q;
        end
        ft_d  = boundary;
    end

    // State and output registers; reset drops everything including a pending load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q        <= '0;
            i_q        <= '0;
            act_dig_q  <= '0;
            act_dp_q   <= '0;
            pend_dig_q <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            seg_q      <= '0;
            dp_q       <= 1'b0;
            an_q       <= '0;
            ft_q       <= 1'b0;
        end else begin
            p_q        <= p_d;
            i_q        <= i_d;
            act_dig_q  <= act_dig_d;
            act_dp_q   <= act_dp_d;
            pend_dig_q <= pend_dig_d;
            pend_dp_q  <= pend_dp_d;
            pend_vld_q <= pend_vld_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            ft_q       <= ft_d;
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign an_out     = an_q;
    assign frame_tick = ft_q;

endmodule
